input_arbiter: RTL and testbench

INPUT_ARBITER -- requirements
Module: input_arbiter

---
 rtl/rapidio_pkg.sv | 19 +
 rtl/rr_select.sv | 28 ++
 rtl/input_arbiter.sv | 152 +++++++++++++++
 tb/tb_input_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapidio_pkg.sv
// rapidio_pkg: shared constants for the RapidIO user-side input path.
// Holds the arbiter state encoding and the default ack timeout.
package rapidio_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_XFER     = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK = 2'd2;

   localparam int ACK_TIMEOUT_DEF = 4096;
   localparam int WAIT_CNT_MIN    = 12;

   // Wait counter is never narrower than WAIT_CNT_MIN bits.
   function automatic int wait_cnt_width(input int timeout);
      int w;
      w = $clog2(timeout);
      return (w > WAIT_CNT_MIN) ? w : WAIT_CNT_MIN;
   endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: round-robin pick of the first set request after ptr.
// Pure combinational; result is one-hot or all zero.
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   // Walk distances 1..NUM_REQ from ptr and keep the first requester hit.
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] &&
                i == (int'(ptr) + k) % NUM_REQ) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/input_arbiter.sv
// input_arbiter: round-robin mux of user streams into the input reader.
// One transfer at a time; grant is held until ack or ack timeout.
module input_arbiter
   import rapidio_pkg::*;
#(
   parameter int NUM_REQ           = 4,
   parameter int DATA_WIDTH        = 64,
   parameter int DATA_LENGTH_WIDTH = 20,
   parameter int ACK_TIMEOUT       = ACK_TIMEOUT_DEF
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]          user_data_in,
   input  logic [NUM_REQ-1:0]                     user_valid_in,
   input  logic [NUM_REQ-1:0]                     user_first_in,
   input  logic [NUM_REQ-1:0]                     user_last_in,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]        user_keep_in,
   input  logic [NUM_REQ*DATA_LENGTH_WIDTH-1:0]   user_len_in,
   output logic [NUM_REQ-1:0]                     user_ready_out,
   output logic [NUM_REQ-1:0]                     user_ack_out,
   output logic [DATA_WIDTH-1:0]                  data_out,
   output logic [DATA_WIDTH/8-1:0]                data_keep_out,
   output logic [DATA_LENGTH_WIDTH-1:0]           data_len_out,
   output logic                                   data_valid_out,
   output logic                                   data_first_out,
   output logic                                   data_last_out,
   input  logic                                   data_ready_in,
   input  logic                                   ack_in,
   output logic [NUM_REQ-1:0]                     grant_out,
   output logic                                   busy_out,
   output logic                                   timeout_err_out
);

   localparam int KW = DATA_WIDTH / 8;
   localparam int LW = DATA_LENGTH_WIDTH;
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = wait_cnt_width(ACK_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   logic [1:0]            state;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    sel;
   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         gidx;
   logic [CW-1:0]         wait_cnt;
   logic [NUM_REQ-1:0]    ack_pulse;
   logic                  timeout_pulse;
   logic                  xfer;
   logic                  beat;
   logic                  gvalid;
   logic                  gfirst;
   logic                  glast;
   logic [DATA_WIDTH-1:0] gdata;
   logic [KW-1:0]         gkeep;
   logic [LW-1:0]         glen;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PW)
   ) u_rr_select (
      .req (req_in),
      .ptr (rr_ptr),
      .gnt (sel)
   );

   // Extract the granted requester's lane from the packed buses.
   always_comb begin
      gidx   = '0;
      gvalid = 1'b0;
      gfirst = 1'b0;
      glast  = 1'b0;
      gdata  = '0;
      gkeep  = '0;
      glen   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gidx   = PW'(i);
            gvalid = user_valid_in[i];
            gfirst = user_first_in[i];
            glast  = user_last_in[i];
            gdata  = user_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            gkeep  = user_keep_in[i*KW +: KW];
            glen   = user_len_in[i*LW +: LW];
         end
      end
   end

   assign xfer = (state == ST_XFER);
   assign beat = xfer & gvalid & data_ready_in;

   assign data_valid_out  = xfer & gvalid;
   assign data_first_out  = xfer & gvalid & gfirst;
   assign data_last_out   = xfer & gvalid & glast;
   assign data_out        = xfer ? gdata : '0;
   assign data_keep_out   = xfer ? gkeep : '0;
   assign data_len_out    = xfer ? glen  : '0;
   assign user_ready_out  = xfer ? (grant & {NUM_REQ{data_ready_in}}) : '0;
   assign grant_out       = grant;
   assign busy_out        = (state != ST_IDLE);
   assign user_ack_out    = ack_pulse;
   assign timeout_err_out = timeout_pulse;

   // Grant FSM, ack wait timer and one-cycle completion/error pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         grant         <= '0;
         rr_ptr        <= PW'(NUM_REQ - 1);
         wait_cnt      <= '0;
         ack_pulse     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         ack_pulse     <= '0;
         timeout_pulse <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (|req_in) begin
                  grant <= sel;
                  state <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (beat && glast) begin
                  wait_cnt <= '0;
                  state    <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (ack_in) begin
                  ack_pulse <= grant;
                  rr_ptr    <= gidx;
                  grant     <= '0;
                  state     <= ST_IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  timeout_pulse <= 1'b1;
                  rr_ptr        <= gidx;
                  grant         <= '0;
                  state         <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               grant <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_arbiter.sv
// tb_input_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grant, stream mux, ack and timeout rules.
module tb_input_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int KW = DW / 8;
   localparam int LW = 20;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_in;
   logic [N*DW-1:0] user_data_in;
   logic [N-1:0]    user_valid_in;
   logic [N-1:0]    user_first_in;
   logic [N-1:0]    user_last_in;
   logic [N*KW-1:0] user_keep_in;
   logic [N*LW-1:0] user_len_in;
   logic [N-1:0]    user_ready_out;
   logic [N-1:0]    user_ack_out;
   logic [DW-1:0]   data_out;
   logic [KW-1:0]   data_keep_out;
   logic [LW-1:0]   data_len_out;
   logic            data_valid_out;
   logic            data_first_out;
   logic            data_last_out;
   logic            data_ready_in;
   logic            ack_in;
   logic [N-1:0]    grant_out;
   logic            busy_out;
   logic            timeout_err_out;

   input_arbiter #(
      .NUM_REQ           (N),
      .DATA_WIDTH        (DW),
      .DATA_LENGTH_WIDTH (LW),
      .ACK_TIMEOUT       (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_in          (req_in),
      .user_data_in    (user_data_in),
      .user_valid_in   (user_valid_in),
      .user_first_in   (user_first_in),
      .user_last_in    (user_last_in),
      .user_keep_in    (user_keep_in),
      .user_len_in     (user_len_in),
      .user_ready_out  (user_ready_out),
      .user_ack_out    (user_ack_out),
      .data_out        (data_out),
      .data_keep_out   (data_keep_out),
      .data_len_out    (data_len_out),
      .data_valid_out  (data_valid_out),
      .data_first_out  (data_first_out),
      .data_last_out   (data_last_out),
      .data_ready_in   (data_ready_in),
      .ack_in          (ack_in),
      .grant_out       (grant_out),
      .busy_out        (busy_out),
      .timeout_err_out (timeout_err_out)
   );

   always #5 clk = ~clk;

   typedef enum int {M_IDLE, M_STREAM, M_AWAIT} mph_t;

   mph_t         m_ph     = M_IDLE;
   int           m_own    = -1;
   int           m_last   = N - 1;
   int           m_waited = 0;
   int           m_ack    = -1;
   bit           m_terr   = 1'b0;
   int           beat_idx [N];
   int           cyc      = 0;
   int           n_cmp    = 0;
   int           n_bad    = 0;
   bit           chk_en   = 1'b0;
   bit           rand_mode = 1'b0;
   bit           tog_dr   = 1'b0;
   int           nb       = 4;
   int           ack_pct  = 10;
   int           dut_log [$];
   int           dut_acc  = 0;
   bit           ng_ready = 1'b0;
   logic [N-1:0] prev_g   = '0;

   localparam int B_EXP [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   function automatic logic bitn(logic [N-1:0] v, int i);
      logic [N-1:0] s;
      s = v >> i;
      return s[0];
   endfunction

   function automatic logic [N-1:0] onehot(int i);
      if (i < 0) return '0;
      return N'(1) << i;
   endfunction

   function automatic int idx_of(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (bitn(v, i)) return i;
      return -1;
   endfunction

   // Round robin: first requester at distance 1..N after the last winner.
   function automatic int pick(logic [N-1:0] r, int last);
      for (int d = 1; d <= N; d++)
         if (bitn(r, (last + d) % N)) return (last + d) % N;
      return -1;
   endfunction

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: advances one transaction step per clock edge.
   always @(posedge clk) begin
      int nack;
      bit nterr;
      nack  = -1;
      nterr = 1'b0;
      cyc++;
      if (reset) begin
         m_ph     = M_IDLE;
         m_own    = -1;
         m_last   = N - 1;
         m_waited = 0;
         foreach (beat_idx[i]) beat_idx[i] = 0;
      end else begin
         case (m_ph)
            M_IDLE: begin
               if (req_in != '0) begin
                  m_own = pick(req_in, m_last);
                  m_ph  = M_STREAM;
               end
            end
            M_STREAM: begin
               if (bitn(user_valid_in, m_own) && data_ready_in) begin
                  if (bitn(user_last_in, m_own)) begin
                     beat_idx[m_own] = 0;
                     m_waited = 0;
                     m_ph     = M_AWAIT;
                  end else begin
                     beat_idx[m_own]++;
                  end
               end
            end
            default: begin
               m_waited++;
               if (ack_in) begin
                  nack   = m_own;
                  m_last = m_own;
                  m_own  = -1;
                  m_ph   = M_IDLE;
               end else if (m_waited == TO) begin
                  nterr  = 1'b1;
                  m_last = m_own;
                  m_own  = -1;
                  m_ph   = M_IDLE;
               end
            end
         endcase
      end
      m_ack  = nack;
      m_terr = nterr;
   end

   // Compare every DUT output with the model mid-cycle.
   always @(negedge clk) begin
      logic [N-1:0]  eg;
      logic [N-1:0]  er;
      logic          ev;
      logic          ef;
      logic          el;
      logic [DW-1:0] ed;
      logic [KW-1:0] ek;
      logic [LW-1:0] elen;
      if (chk_en) begin
         eg   = onehot(m_own);
         er   = '0;
         ev   = 1'b0;
         ef   = 1'b0;
         el   = 1'b0;
         ed   = '0;
         ek   = '0;
         elen = '0;
         if (m_ph == M_STREAM) begin
            ev   = bitn(user_valid_in, m_own);
            ef   = ev & bitn(user_first_in, m_own);
            el   = ev & bitn(user_last_in, m_own);
            ed   = user_data_in[m_own*DW +: DW];
            ek   = user_keep_in[m_own*KW +: KW];
            elen = user_len_in[m_own*LW +: LW];
            er   = data_ready_in ? eg : '0;
         end
         chk("grant_out", grant_out, eg);
         chk("busy_out", busy_out, (m_ph != M_IDLE));
         chk("user_ready_out", user_ready_out, er);
         chk("data_valid_out", data_valid_out, ev);
         chk("data_first_out", data_first_out, ef);
         chk("data_last_out", data_last_out, el);
         chk("data_out", data_out, ed);
         chk("data_keep_out", data_keep_out, ek);
         chk("data_len_out", data_len_out, elen);
         chk("user_ack_out", user_ack_out, onehot(m_ack));
         chk("timeout_err_out", timeout_err_out, m_terr);
         if (data_valid_out && data_ready_in) dut_acc++;
         if ((user_ready_out & ~grant_out) != '0) ng_ready = 1'b1;
         if (grant_out != '0 && prev_g == '0)
            dut_log.push_back(idx_of(grant_out));
         prev_g = grant_out;
      end
   end

   task automatic lanes();
      for (int i = 0; i < N; i++) begin
         user_valid_in[i] = 1'b1;
         user_first_in[i] = (beat_idx[i] == 0);
         user_last_in[i]  = (beat_idx[i] == nb - 1);
         user_data_in[i*DW +: DW] = {$urandom(), $urandom()};
         user_keep_in[i*KW +: KW] = KW'($urandom());
         user_len_in[i*LW +: LW]  = LW'(nb * 8 - 1);
      end
   endtask

   task automatic rand_lanes();
      req_in = N'($urandom()) & N'($urandom());
      for (int i = 0; i < N; i++) begin
         user_valid_in[i] = ($urandom_range(0, 3) != 0);
         user_first_in[i] = $urandom_range(0, 1) == 1;
         user_last_in[i]  = ($urandom_range(0, 9) < 3);
         user_data_in[i*DW +: DW] = {$urandom(), $urandom()};
         user_keep_in[i*KW +: KW] = KW'($urandom());
         user_len_in[i*LW +: LW]  = LW'($urandom());
      end
      data_ready_in = ($urandom_range(0, 9) < 7);
      ack_in        = ($urandom_range(0, 99) < ack_pct);
      reset         = ($urandom_range(0, 999) < 3);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      if (rand_mode) rand_lanes();
      else lanes();
      if (tog_dr) data_ready_in = ~data_ready_in;
   endtask

   task automatic wait_phase(mph_t ph, int budget, string nm);
      int k;
      k = 0;
      while (m_ph != ph && k < budget) begin
         tick();
         k++;
      end
      if (m_ph != ph) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: phase not reached within %0d cycles", nm, budget);
      end
   endtask

   task automatic do_reset(bit pin);
      reset         = 1'b1;
      req_in        = '0;
      ack_in        = 1'b0;
      data_ready_in = 1'b1;
      tog_dr        = 1'b0;
      lanes();
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      if (pin) begin
         chk("rst_grant", grant_out, 0);
         chk("rst_busy", busy_out, 0);
         chk("rst_valid", data_valid_out, 0);
         chk("rst_data", data_out, 0);
         chk("rst_ready", user_ready_out, 0);
         chk("rst_ack", user_ack_out, 0);
         chk("rst_err", timeout_err_out, 0);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic finish_xfer(string nm);
      wait_phase(M_AWAIT, 40, nm);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
   endtask

   initial begin
      int  c0;
      bit  got;
      bit  ack_seen;

      // A: single requester, 4 beats, ack 10 cycles after last.
      do_reset(1'b1);
      nb = 4;
      req_in = 4'b0001;
      tick();
      req_in = 4'b0000;
      @(negedge clk);
      chk("A_grant", grant_out, 4'b0001);
      wait_phase(M_AWAIT, 20, "A_last");
      repeat (9) tick();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      @(negedge clk);
      chk("A_ack", user_ack_out, 4'b0001);
      chk("A_no_err", timeout_err_out, 0);
      tick();
      @(negedge clk);
      chk("A_ack_once", user_ack_out, 0);
      chk("A_idle", busy_out, 0);

      // B: all four requesting for 8 transfers.
      do_reset(1'b0);
      nb = 2;
      req_in = 4'b1111;
      dut_log.delete();
      for (int t = 0; t < 8; t++) begin
         finish_xfer("B_xfer");
         if (t == 7) req_in = 4'b0000;
      end
      tick();
      chk("B_count", dut_log.size(), 8);
      for (int t = 0; t < 8 && t < dut_log.size(); t++)
         chk("B_order", dut_log[t], B_EXP[t]);

      // C: 6-beat transfer with ready toggling.
      do_reset(1'b0);
      nb = 6;
      req_in = 4'b0100;
      tick();
      req_in = 4'b0000;
      dut_acc  = 0;
      ng_ready = 1'b0;
      tog_dr   = 1'b1;
      wait_phase(M_AWAIT, 40, "C_last");
      tog_dr = 1'b0;
      data_ready_in = 1'b1;
      @(negedge clk);
      chk("C_beats", dut_acc, 6);
      chk("C_other_ready", ng_ready, 0);
      finish_xfer("C_ack");

      // D: no ack, timeout 16 cycles after WAIT_ACK entry.
      do_reset(1'b0);
      nb = 1;
      req_in = 4'b0010;
      wait_phase(M_AWAIT, 10, "D_last");
      req_in   = 4'b0001;
      c0       = cyc;
      got      = 1'b0;
      ack_seen = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         @(negedge clk);
         if (user_ack_out != '0) ack_seen = 1'b1;
         if (timeout_err_out) got = 1'b1;
      end
      chk("D_delay", cyc - c0, TO);
      chk("D_no_ack", ack_seen, 0);
      tick();
      @(negedge clk);
      chk("D_regrant", grant_out, 4'b0001);
      req_in = 4'b0000;
      finish_xfer("D_ack");

      // E: early ack ignored; ack coincident with timeout wins.
      do_reset(1'b0);
      nb = 3;
      req_in = 4'b1000;
      tick();
      req_in = 4'b0000;
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      @(negedge clk);
      chk("E_early_ack", user_ack_out, 0);
      chk("E_still_busy", busy_out, 1);
      wait_phase(M_AWAIT, 10, "E_last");
      repeat (TO - 1) tick();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      @(negedge clk);
      chk("E_ack_wins", user_ack_out, 4'b1000);
      chk("E_no_err", timeout_err_out, 0);
      tick();
      @(negedge clk);
      chk("E_after_err", timeout_err_out, 0);

      // F: reset in the third beat aborts silently.
      do_reset(1'b0);
      nb = 5;
      req_in = 4'b0100;
      tick();
      req_in = 4'b0000;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("F_grant", grant_out, 0);
      chk("F_busy", busy_out, 0);
      chk("F_valid", data_valid_out, 0);
      chk("F_data", data_out, 0);
      chk("F_ready", user_ready_out, 0);
      chk("F_ack", user_ack_out, 0);
      chk("F_err", timeout_err_out, 0);
      req_in = 4'b1111;
      tick();
      req_in = 4'b0000;
      @(negedge clk);
      chk("F_prio", grant_out, 4'b0001);
      finish_xfer("F_ack");

      // G: random traffic, alternating frequent and sparse acks.
      rand_mode = 1'b1;
      for (int blk = 0; blk < 6; blk++) begin
         ack_pct = (blk % 2 == 1) ? 3 : 15;
         repeat (500) tick();
      end
      rand_mode = 1'b0;
      reset = 1'b0;
      tick();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
